// File: rtl/adder_sched_pkg.sv
// Shared types and defaults for the scheduled adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_sched_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic [PW-1:0] idx;

    // Scan offsets from far to near so the nearest request to ptr wins;
    // NREQ is a power of two so the PW-bit add wraps modulo NREQ.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + PW'(k);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduled adder: picks one requester, registers a+b with carry.
// Latency: one cycle from transfer to res_valid.
// Backpressure: req_ready held low while the result register is full and unconsumed.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_carry,
    output logic [IDW-1:0]        res_id,
    output logic [7:0]            ovf_count
);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   sum;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (IDW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    // A slot is free when empty or when the held result leaves this cycle.
    assign accept    = (state == EMPTY) || res_ready;
    assign req_ready = (rst_n && accept) ? gnt : '0;
    assign xfer      = |req_ready;
    assign res_valid = (state == FULL);

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_idx = IDW'(i);
        end
        sel_a = req_a[gnt_idx*WIDTH +: WIDTH];
        sel_b = req_b[gnt_idx*WIDTH +: WIDTH];
        sum   = {1'b0, sel_a} + {1'b0, sel_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
            ovf_count <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                res_data  <= sum[WIDTH-1:0];
                res_carry <= sum[WIDTH];
                res_id    <= gnt_idx;
                ptr       <= gnt_idx + IDW'(1);
                if (sum[WIDTH] && (ovf_count != 8'hFF))
                    ovf_count <= ovf_count + 8'd1;
            end
            case (state)
                EMPTY:   if (xfer) state <= FULL;
                FULL:    if (res_ready && !xfer) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sched.sv
// Randomized bench for adder_sched against a cycle-level behavioural model.
module tb_adder_sched;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_data;
    logic           res_carry;
    logic [1:0]     res_id;
    logic [7:0]     ovf_count;

    adder_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_id    (res_id),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: held result, last-granted-based search start, overflow tally.
    int m_full, m_data, m_carry, m_id, m_ovf, m_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_data = 0; m_carry = 0; m_id = 0; m_ovf = 0; m_ptr = 0;
    endtask

    function automatic int exp_grant();
        int g = -1;
        if (m_full != 0 && !res_ready) return -1;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        return g;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".res_valid"}, res_valid, m_full);
        check({tag, ".res_data"},  res_data,  m_data);
        check({tag, ".res_carry"}, res_carry, m_carry);
        check({tag, ".res_id"},    res_id,    m_id);
        check({tag, ".ovf_count"}, ovf_count, m_ovf);
    endtask

    // Inputs already applied; check grant, advance model across one rising edge.
    task automatic tick(input string tag);
        int g, s;
        #1;
        g = exp_grant();
        check({tag, ".req_ready"}, req_ready, (g >= 0) ? (1 << g) : 0);
        if (g >= 0) begin
            s       = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
            m_data  = s % 256;
            m_carry = (s >= 256) ? 1 : 0;
            m_id    = g;
            m_full  = 1;
            m_ptr   = (g + 1) % N;
            if (m_carry != 0 && m_ovf < 255) m_ovf++;
        end else if (res_ready) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic step(input string tag, input logic [N-1:0] v, input logic rr);
        @(negedge clk);
        req_valid = v;
        res_ready = rr;
        tick(tag);
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    int         ids[5];
    logic [7:0] hold_data, hold_ovf;
    logic [1:0] hold_id;

    initial begin
        rst_n = 1'b0; req_valid = '1; res_ready = 1'b0; req_a = '0; req_b = '0;
        model_reset();
        #1;
        check("reset.req_ready", req_ready, 0);
        check_outputs("reset");
        #12;
        req_valid = '0;
        rst_n     = 1'b1;

        set_ops(0, 5, 2);
        step("r034", 4'b0001, 1'b1);
        check("r034.data_abs", res_data, 7);
        check("r034.id_abs", res_id, 0);

        set_ops(1, 10, 5);
        step("r035a", 4'b0010, 1'b1);
        check("r035a.data_abs", res_data, 15);
        check("r035a.id_abs", res_id, 1);
        set_ops(1, 200, 100);
        step("r035b", 4'b0010, 1'b1);
        check("r035b.data_abs", res_data, 44);
        check("r035b.carry_abs", res_carry, 1);
        check("r035b.ovf_abs", ovf_count, 1);
        step("drain", 4'b0000, 1'b1);

        // Grant requester 3 so the rotation restarts at 0.
        rand_ops();
        step("r036pre", 4'b1000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            step("r036", 4'b1111, 1'b1);
            ids[k] = int'(res_id);
        end
        for (int k = 0; k < 5; k++) check("r036.seq", ids[k], k % 4);

        step("r037a", 4'b1111, 1'b1);
        hold_data = res_data; hold_id = res_id;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            step("r037hold", 4'b1111, 1'b0);
            check("r037.data_stable", res_data, hold_data);
            check("r037.id_stable", res_id, hold_id);
        end
        step("r037go", 4'b1111, 1'b1);

        step("r038a", 4'b0100, 1'b1);
        hold_data = res_data; hold_id = res_id; hold_ovf = ovf_count;
        for (int k = 0; k < 10; k++) begin
            rand_ops();
            step("r038idle", 4'b0000, 1'($urandom_range(0, 1)));
            check("r038.data", res_data, hold_data);
            check("r038.id", res_id, hold_id);
            check("r038.ovf", ovf_count, hold_ovf);
        end

        for (int i = 0; i < N; i++) set_ops(i, 255, 255);
        for (int k = 0; k < 260; k++) step("sat", 4'b1111, 1'b1);
        check("sat.ovf_abs", ovf_count, 255);

        rand_ops();
        step("r039full", 4'b0001, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; req_valid = '1; res_ready = 1'b1;
        #1;
        model_reset();
        check("r039.req_ready_in_reset", req_ready, 0);
        check_outputs("r039rst");
        #1;
        rst_n = 1'b1;
        tick("r039first");
        check("r039.id_abs", res_id, 0);

        for (int k = 0; k < 1500; k++) begin
            rand_ops();
            step("rand", N'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_sched.md
ADDER_SCHED -- requirements
Module: adder_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters (power of two, 2..8).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester operand pair valid.
REQ-006 The block SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 The block SHALL have port req_a  input  NREQ*WIDTH  operand A, requester i in slice [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port req_b  input  NREQ*WIDTH  operand B, same slicing as req_a.
REQ-009 The block SHALL have port res_valid  output  1  result register holds an unconsumed result.
REQ-010 The block SHALL have port res_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port res_data  output  WIDTH  sum modulo 2^WIDTH.
REQ-012 The block SHALL have port res_carry  output  1  carry-out of the sum.
REQ-013 The block SHALL have port res_id  output  clog2(NREQ)  index of the requester that produced the result.
REQ-014 The block SHALL have port ovf_count  output  8  saturating count of results with carry-out.

Function
REQ-015 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-016 req_ready SHALL be all-zero when no requester is valid or when the result register is full and res_ready is low.
REQ-017 Among valid requesters, grant SHALL be round-robin: search starts at index (last granted + 1) mod NREQ; after reset search starts at 0.
REQ-018 req_ready SHALL be combinational from req_valid, the round-robin pointer, res_valid and res_ready.
REQ-019 A transfer in cycle N SHALL present res_valid=1, res_data=(a+b) mod 2^WIDTH, res_carry, res_id in cycle N+1 (one-cycle latency).
REQ-020 FSM SHALL have states EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-021 EMPTY -> FULL on a transfer; FULL -> EMPTY on res_ready with no transfer; FULL stays FULL on res_ready with transfer (back-to-back, one result per cycle); FULL holds on res_ready low.
REQ-022 While FULL and res_ready low, res_data, res_carry and res_id SHALL remain stable.
REQ-023 Result outputs and ovf_count SHALL change only as a consequence of a transfer; with req_valid all-zero they SHALL never change.
REQ-024 The round-robin pointer SHALL update only on a transfer.
REQ-025 ovf_count SHALL increment when a result with carry-out is loaded and SHALL saturate at 255.
REQ-026 Operand changes on a non-granted requester SHALL have no effect on any output other than req_ready.

Reset
REQ-027 On rst_n low, asynchronously: state EMPTY, res_valid=0, res_data=0, res_carry=0, res_id=0, ovf_count=0, pointer=0.
REQ-028 req_ready SHALL be all-zero while rst_n is low.
REQ-029 Reset asserted while FULL SHALL discard the pending result with no transfer reported.
REQ-030 After rst_n deasserts, first grant SHALL be possible on the first rising clk edge.

Structure
REQ-031 Package adder_sched_pkg SHALL hold the state enum (EMPTY, FULL) and default WIDTH/NREQ constants.
REQ-032 Round-robin grant logic SHALL be a separate sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).
REQ-033 The adder SHALL be one WIDTH+1 bit addition feeding the result register; no other arithmetic.

Verification
REQ-034 Requester 0 a=5 b=2, res_ready=1 -> next cycle res_valid=1, res_data=7, res_carry=0, res_id=0.
REQ-035 Requester 1 a=10 b=5 -> res_data=15, res_id=1; then a=200 b=100 -> res_data=44, res_carry=1, ovf_count=1.
REQ-036 All four valid continuously, res_ready=1 -> res_id sequence 0,1,2,3,0 on consecutive cycles.
REQ-037 res_ready=0 for 3 cycles after a result -> res_data/res_id stable, req_ready all-zero; on res_ready=1, next grant same cycle.
REQ-038 req_valid all-zero for 10 cycles after one result -> res_data, res_id, ovf_count unchanged throughout.
REQ-039 rst_n pulsed low while FULL -> res_valid=0 immediately, ovf_count=0, next grant to requester 0 when all valid.
